// File: rtl/a2d_pkg.sv
// Shared types and constants for the A2D conversion interface.
// Optional feature macro used by this slice: A2D_ERR_CHK_EN (see a2d_intf).
package a2d_pkg;

    typedef enum logic [2:0] {IDLE, FRM1, GAP, FRM2, DONE} a2d_state_t;

    localparam int FRAME_BITS   = 16;
    localparam int RES_BITS     = 12;
    localparam int CMD_CHNL_LSB = 11;

    // Command word sent in both frames: channel address in bits [13:11].
    function automatic logic [FRAME_BITS-1:0] a2d_cmd(input logic [2:0] ch);
        logic [FRAME_BITS-1:0] w;
        w = '0;
        w[CMD_CHNL_LSB +: 3] = ch;
        return w;
    endfunction

endpackage

// File: rtl/spi_mstr16.sv
// 16-bit SPI master (mode 3: SCLK idles high, MOSI changes on SCLK fall,
// MISO sampled on SCLK rise). One frame per wrt pulse; done pulses for one
// clk on the cycle SS_n returns high, with rd_data holding the received word.
module spi_mstr16
    import a2d_pkg::*;
#(
    parameter int SCLK_DIV = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wrt,
    input  logic [FRAME_BITS-1:0] cmd,
    output logic                  done,
    output logic [FRAME_BITS-1:0] rd_data,
    output logic                  SS_n,
    output logic                  SCLK,
    output logic                  MOSI,
    input  logic                  MISO
);

    localparam int CW = $clog2(SCLK_DIV);
    localparam int BW = $clog2(FRAME_BITS + 1);
    localparam logic [CW-1:0] HALF     = CW'(SCLK_DIV / 2);
    localparam logic [CW-1:0] PRE_RISE = CW'(SCLK_DIV / 2 - 1);
    localparam logic [CW-1:0] LAST     = CW'(SCLK_DIV - 1);
    localparam logic [BW-1:0] NBITS    = BW'(FRAME_BITS);

    logic [CW-1:0]         cnt;
    logic [BW-1:0]         rises;
    logic [FRAME_BITS-1:0] tx;

    // SCLK is the divider MSB; the counter parks at all-ones so SCLK idles high.
    assign SCLK = cnt[CW-1];

    // Frame sequencing: front porch from the HALF preload, 16 SCLK periods,
    // then a half-period back porch before SS_n is released.
    always_ff @(posedge clk) begin
        if (rst) begin
            SS_n    <= 1'b1;
            cnt     <= LAST;
            rises   <= '0;
            tx      <= '0;
            MOSI    <= 1'b0;
            rd_data <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (SS_n) begin
                if (wrt) begin
                    SS_n  <= 1'b0;
                    cnt   <= HALF;
                    rises <= '0;
                    tx    <= cmd;
                end
            end else if (cnt == LAST && rises == NBITS) begin
                // back porch finished: counter stays at LAST, SCLK stays high
                SS_n <= 1'b1;
                MOSI <= 1'b0;
                done <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
                if (cnt == LAST) begin
                    // wrap to 0 = SCLK fall: present next bit, MSB first
                    MOSI <= tx[FRAME_BITS-1];
                    tx   <= {tx[FRAME_BITS-2:0], 1'b0};
                end
                if (cnt == PRE_RISE) begin
                    // reaching HALF = SCLK rise: sample MISO
                    rd_data <= {rd_data[FRAME_BITS-2:0], MISO};
                    rises   <= rises + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/a2d_intf.sv
// Conversion handshake responder for an ADC128S-style 8-channel 12-bit A2D.
// Each start_conv accepted in IDLE runs two SPI frames (address, then data)
// and returns A2D_res with a one-clk cnv_cmplt pulse.
// Build option: define A2D_ERR_CHK_EN to add the a2d_err output, which flags
// a non-zero leading nibble in the frame-2 word.
module a2d_intf
    import a2d_pkg::*;
#(
    parameter int SCLK_DIV = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_conv,
    input  logic [2:0]          chnnl,
    output logic                cnv_cmplt,
    output logic [RES_BITS-1:0] A2D_res,
    output logic                SS_n,
    output logic                SCLK,
    output logic                MOSI,
`ifdef A2D_ERR_CHK_EN
    output logic                a2d_err,
`endif
    input  logic                MISO
);

    localparam int CW = $clog2(SCLK_DIV);
    // done is seen one clk after SS_n rises and wrt takes one clk to lower
    // SS_n again, so the counted part of the gap is two clks short of half.
    localparam logic [CW-1:0] GAP_LAST = CW'(SCLK_DIV / 2 - 3);

    a2d_state_t            state;
    logic [2:0]            ch_q;
    logic                  wrt;
    logic [CW-1:0]         gap_cnt;
    logic                  done;
    logic [FRAME_BITS-1:0] rd_data;

    spi_mstr16 #(.SCLK_DIV(SCLK_DIV)) u_spi (
        .clk     (clk),
        .rst     (rst),
        .wrt     (wrt),
        .cmd     (a2d_cmd(ch_q)),
        .done    (done),
        .rd_data (rd_data),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .MISO    (MISO)
    );

`ifndef A2D_ERR_CHK_EN
    // leading nibble is not checked in this build
    logic [FRAME_BITS-RES_BITS-1:0] rx_hi_unused;
    assign rx_hi_unused = rd_data[FRAME_BITS-1:RES_BITS];
`endif

    // Conversion sequencer; the result and cnv_cmplt are registered on entry
    // to DONE so the pulse lines up with the DONE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ch_q      <= '0;
            wrt       <= 1'b0;
            gap_cnt   <= '0;
            cnv_cmplt <= 1'b0;
            A2D_res   <= '0;
`ifdef A2D_ERR_CHK_EN
            a2d_err   <= 1'b0;
`endif
        end else begin
            wrt       <= 1'b0;
            cnv_cmplt <= 1'b0;
            case (state)
                IDLE: if (start_conv) begin
                    ch_q  <= chnnl;
                    wrt   <= 1'b1;
                    state <= FRM1;
                end
                FRM1: if (done) begin
                    gap_cnt <= '0;
                    state   <= GAP;
                end
                GAP: if (gap_cnt == GAP_LAST) begin
                    wrt   <= 1'b1;
                    state <= FRM2;
                end else begin
                    gap_cnt <= gap_cnt + 1'b1;
                end
                FRM2: if (done) begin
                    cnv_cmplt <= 1'b1;
                    A2D_res   <= rd_data[RES_BITS-1:0];
`ifdef A2D_ERR_CHK_EN
                    a2d_err   <= |rd_data[FRAME_BITS-1:RES_BITS];
`endif
                    state     <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
